// File: rtl/ahb_sram_slave.sv
// ---------------------------------------------------------------------------------------------
// ahb_sram_slave
//
// AHB-Lite slave in front of a DEPTH x 32-bit word memory. Each accepted transfer has a
// data phase that is stretched by WAIT_STATES hready-low cycles. Unaligned accesses get a
// two-cycle ERROR response.
//
// Optional feature (macro AHB_SRAM_SLAVE_RANGE_CHECK_EN):
//   defined   - an access with haddr >= 4*DEPTH gets the two-cycle ERROR response
//   undefined - upper address bits are ignored and the word index wraps modulo DEPTH
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 16..4096)
//   WAIT_STATES  hready-low cycles per OKAY data phase (0..3)
//
// Ports:
//   hclk    in   bus clock, rising edge
//   resetN  in   asynchronous active-low reset
//   hsel    in   slave select
//   haddr   in   byte address, word index = haddr[log2(DEPTH)+1:2]
//   hwdata  in   write data (data phase)
//   hwrite  in   1 = write, 0 = read (address phase)
//   htrans  in   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//   hready  out  data phase complete; also the bus hready seen by this slave
//   hresp   out  00 OKAY, 01 ERROR
//   hrdata  out  read data, held between read data phases
// ---------------------------------------------------------------------------------------------
module ahb_sram_slave #(
   parameter int unsigned DEPTH       = 256,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        hclk,
   input  logic        resetN,
   input  logic        hsel,
   input  logic [31:0] haddr,
   input  logic [31:0] hwdata,
   input  logic        hwrite,
   input  logic [1:0]  htrans,
   output logic        hready,
   output logic [1:0]  hresp,
   output logic [31:0] hrdata
);

   localparam int unsigned AW = $clog2(DEPTH);

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StErr1,
      StErr2
   } state_e;

   state_e          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;        // remaining hready-low cycles in StWait
   logic            dp_valid_q, dp_valid_d;
   logic            dp_write_q, dp_write_d;
   logic [AW-1:0]   dp_idx_q, dp_idx_d;
   logic [31:0]     hrdata_q, hrdata_d;

   logic [31:0]     mem [DEPTH];

   logic [AW-1:0]   addr_idx;
   logic            accept;
   logic            addr_err;
   logic            mem_we;
   logic            hready_d;
   logic            load_rd;

   assign addr_idx = haddr[AW+1:2];
   assign accept   = hsel & htrans[1] & hready;

`ifdef AHB_SRAM_SLAVE_RANGE_CHECK_EN
   assign addr_err = (haddr[1:0] != 2'b00) || (haddr[31:AW+2] != '0);
`else
   logic unused_upper_addr;
   assign unused_upper_addr = ^haddr[31:AW+2];
   assign addr_err          = (haddr[1:0] != 2'b00);
`endif

   // hready depends only on registered state, so it is glitch-free towards the bus.
   always_comb begin
      hready = 1'b1;
      if (state_q == StErr1) begin
         hready = 1'b0;
      end else if ((state_q == StWait) && (cnt_q != 2'd0)) begin
         hready = 1'b0;
      end
   end

   always_comb begin
      hresp = 2'b00;
      if ((state_q == StErr1) || (state_q == StErr2)) begin
         hresp = 2'b01;
      end
   end

   assign hrdata = hrdata_q;

   // The pending data phase completes on any edge where hready is high.
   assign mem_we = dp_valid_q & dp_write_q & hready;

   // Next-state logic
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dp_valid_d = dp_valid_q;
      dp_write_d = dp_write_q;
      dp_idx_d   = dp_idx_q;

      if (hready) begin
         // Current data phase (if any) finishes; optionally a new address phase starts.
         state_d    = StIdle;
         dp_valid_d = 1'b0;
         if (accept) begin
            if (addr_err) begin
               state_d = StErr1;
            end else begin
               dp_valid_d = 1'b1;
               dp_write_d = hwrite;
               dp_idx_d   = addr_idx;
               if (WAIT_STATES > 0) begin
                  state_d = StWait;
                  cnt_d   = 2'(WAIT_STATES);
               end
            end
         end
      end else begin
         unique case (state_q)
            StErr1:  state_d = StErr2;
            StWait:  cnt_d   = cnt_q - 2'd1;
            default: state_d = state_q;
         endcase
      end
   end

   // hready of the next cycle, used to time the hrdata load into the completing data phase.
   always_comb begin
      hready_d = 1'b1;
      if (state_d == StErr1) begin
         hready_d = 1'b0;
      end else if ((state_d == StWait) && (cnt_d != 2'd0)) begin
         hready_d = 1'b0;
      end
   end

   assign load_rd = dp_valid_d & ~dp_write_d & hready_d;

   // A read whose data phase follows a write to the same word sees the data being written.
   always_comb begin
      hrdata_d = hrdata_q;
      if (load_rd) begin
         if (mem_we && (dp_idx_q == dp_idx_d)) begin
            hrdata_d = hwdata;
         end else begin
            hrdata_d = mem[dp_idx_d];
         end
      end
   end

   always_ff @(posedge hclk or negedge resetN) begin
      if (!resetN) begin
         state_q    <= StIdle;
         cnt_q      <= 2'd0;
         dp_valid_q <= 1'b0;
         dp_write_q <= 1'b0;
         dp_idx_q   <= '0;
         hrdata_q   <= 32'h0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         dp_valid_q <= dp_valid_d;
         dp_write_q <= dp_write_d;
         dp_idx_q   <= dp_idx_d;
         hrdata_q   <= hrdata_d;
      end
   end

   // Memory array is deliberately not reset; reset clears dp_valid_q so no write can follow.
   always_ff @(posedge hclk) begin
      if (mem_we) begin
         mem[dp_idx_q] <= hwdata;
      end
   end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Directed bench for ahb_sram_slave: one instance with WAIT_STATES=0 and one with WAIT_STATES=2
// share the bus inputs; each section checks only its own instance's outputs.
module tb_ahb_sram_slave;

   localparam logic [1:0] TR_IDLE   = 2'b00;
   localparam logic [1:0] TR_BUSY   = 2'b01;
   localparam logic [1:0] TR_NONSEQ = 2'b10;
   localparam logic [1:0] TR_SEQ    = 2'b11;

   logic        hclk;
   logic        resetN;
   logic        hsel;
   logic [31:0] haddr;
   logic [31:0] hwdata;
   logic        hwrite;
   logic [1:0]  htrans;

   logic        hready0, hready2;
   logic [1:0]  hresp0, hresp2;
   logic [31:0] hrdata0, hrdata2;

   int checks = 0;
   int errors = 0;

   ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(0)) dut0 (
      .hclk   (hclk),
      .resetN (resetN),
      .hsel   (hsel),
      .haddr  (haddr),
      .hwdata (hwdata),
      .hwrite (hwrite),
      .htrans (htrans),
      .hready (hready0),
      .hresp  (hresp0),
      .hrdata (hrdata0)
   );

   ahb_sram_slave #(.DEPTH(256), .WAIT_STATES(2)) dut2 (
      .hclk   (hclk),
      .resetN (resetN),
      .hsel   (hsel),
      .haddr  (haddr),
      .hwdata (hwdata),
      .hwrite (hwrite),
      .htrans (htrans),
      .hready (hready2),
      .hresp  (hresp2),
      .hrdata (hrdata2)
   );

   initial begin
      hclk = 1'b0;
      forever #5 hclk = ~hclk;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   task automatic set_bus(input logic sel, input logic [1:0] tr, input logic wr,
                          input logic [31:0] a, input logic [31:0] wd);
      hsel   = sel;
      htrans = tr;
      hwrite = wr;
      haddr  = a;
      hwdata = wd;
   endtask

   // Advance to just after the next rising edge.
   task automatic step();
      @(posedge hclk);
      #1;
   endtask

   initial begin
      resetN = 1'b0;
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      #2;
      chk("rst hready", 32'(hready0), 32'd1);
      chk("rst hresp", 32'(hresp0), 32'd0);
      chk("rst hrdata", hrdata0, 32'h0);
      step();
      step();
      resetN = 1'b1;

      // ---------------- WAIT_STATES = 0 ----------------
      // Write DEADBEEF to 0x10, read it back-to-back (forwarded).
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h10, 32'h0);
      chk("w10 addr hready", 32'(hready0), 32'd1);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h10, 32'hDEAD_BEEF);
      chk("w10 data hready", 32'(hready0), 32'd1);
      chk("w10 data hresp", 32'(hresp0), 32'd0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("r10 hready", 32'(hready0), 32'd1);
      chk("r10 hresp", 32'(hresp0), 32'd0);
      chk("r10 fwd hrdata", hrdata0, 32'hDEAD_BEEF);
      step();

      // Non-forwarded read of 0x14, then hold check.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h14, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h1234_5678);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h14, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("r14 hrdata", hrdata0, 32'h1234_5678);
      step();
      chk("r14 hold hrdata", hrdata0, 32'h1234_5678);

      // Back-to-back writes 0x0/0x4/0x8 then reads.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h0, 32'h0);
      step();
      set_bus(1'b1, TR_SEQ, 1'b1, 32'h4, 32'hA000_0000);
      chk("b2b w hready0", 32'(hready0), 32'd1);
      step();
      set_bus(1'b1, TR_SEQ, 1'b1, 32'h8, 32'hA000_0001);
      chk("b2b w hready1", 32'(hready0), 32'd1);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h0, 32'hA000_0002);
      chk("b2b w hready2", 32'(hready0), 32'd1);
      step();
      set_bus(1'b1, TR_SEQ, 1'b0, 32'h4, 32'h0);
      chk("b2b r0", hrdata0, 32'hA000_0000);
      step();
      set_bus(1'b1, TR_SEQ, 1'b0, 32'h8, 32'h0);
      chk("b2b r1", hrdata0, 32'hA000_0001);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("b2b r2", hrdata0, 32'hA000_0002);
      chk("b2b r2 hready", 32'(hready0), 32'd1);
      step();

      // Unaligned write to 0x2: ERR1, ERR2, no memory change.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h2, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'hBAD0_BAD0);
      chk("err1 hready", 32'(hready0), 32'd0);
      chk("err1 hresp", 32'(hresp0), 32'd1);
      chk("err1 hrdata", hrdata0, 32'hA000_0002);
      step();
      chk("err2 hready", 32'(hready0), 32'd1);
      chk("err2 hresp", 32'(hresp0), 32'd1);
      step();
      chk("post err hresp", 32'(hresp0), 32'd0);
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h0, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("err mem0 intact", hrdata0, 32'hA000_0000);
      step();

      // Address during ERR1 ignored, address during ERR2 accepted.
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h3, 32'h0);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h4, 32'h5A5A_5A5A);
      chk("err1b hready", 32'(hready0), 32'd0);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h8, 32'h5A5A_5A5A);
      chk("err2b hready", 32'(hready0), 32'd1);
      chk("err2b hresp", 32'(hresp0), 32'd1);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h4, 32'h0);
      chk("err2 accepted read", hrdata0, 32'hA000_0002);
      chk("err2 accepted hresp", 32'(hresp0), 32'd0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("err1 ignored write", hrdata0, 32'hA000_0001);
      step();

      // Out-of-range 0x400.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h400, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h5555_AAAA);
`ifdef AHB_SRAM_SLAVE_RANGE_CHECK_EN
      chk("range err1 hready", 32'(hready0), 32'd0);
      chk("range err1 hresp", 32'(hresp0), 32'd1);
      step();
      chk("range err2 hresp", 32'(hresp0), 32'd1);
`else
      chk("range okay hready", 32'(hready0), 32'd1);
      chk("range okay hresp", 32'(hresp0), 32'd0);
`endif
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h0, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
`ifdef AHB_SRAM_SLAVE_RANGE_CHECK_EN
      chk("range mem0", hrdata0, 32'hA000_0000);
`else
      chk("range alias mem0", hrdata0, 32'h5555_AAAA);
`endif
      step();

      // IDLE/BUSY with hsel=1 and NONSEQ with hsel=0: no access.
      set_bus(1'b1, TR_IDLE, 1'b1, 32'h0, 32'h0);
      step();
      set_bus(1'b1, TR_BUSY, 1'b1, 32'h0, 32'h7777_7777);
      chk("idle sel hready", 32'(hready0), 32'd1);
      chk("idle sel hresp", 32'(hresp0), 32'd0);
      step();
      set_bus(1'b0, TR_NONSEQ, 1'b1, 32'h0, 32'h7777_7777);
      chk("busy sel hready", 32'(hready0), 32'd1);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h7777_7777);
      chk("nosel hready", 32'(hready0), 32'd1);
      chk("nosel hresp", 32'(hresp0), 32'd0);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h0, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
`ifdef AHB_SRAM_SLAVE_RANGE_CHECK_EN
      chk("no-access mem0", hrdata0, 32'hA000_0000);
`else
      chk("no-access mem0", hrdata0, 32'h5555_AAAA);
`endif
      step();

      // ---------------- WAIT_STATES = 2 ----------------
      resetN = 1'b0;
      #1;
      chk("ws rst hrdata", hrdata2, 32'h0);
      chk("ws rst hready", 32'(hready2), 32'd1);
      step();
      resetN = 1'b1;

      // Write C0FFEE00 to 0x4, then read it with stray transfers offered during waits.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h4, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'hC0FF_EE00);
      chk("ws w cyc1 hready", 32'(hready2), 32'd0);
      step();
      chk("ws w cyc2 hready", 32'(hready2), 32'd0);
      step();
      chk("ws w done hready", 32'(hready2), 32'd1);
      chk("ws w done hresp", 32'(hresp2), 32'd0);
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h4, 32'hC0FF_EE00);
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h8, 32'h1111_1111);
      chk("ws r cyc1 hready", 32'(hready2), 32'd0);
      chk("ws r hold hrdata", hrdata2, 32'h0);
      step();
      chk("ws r cyc2 hready", 32'(hready2), 32'd0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h0);
      chk("ws r done hready", 32'(hready2), 32'd1);
      chk("ws r done hresp", 32'(hresp2), 32'd0);
      chk("ws r hrdata", hrdata2, 32'hC0FF_EE00);
      step();
      chk("ws stray ignored", 32'(hready2), 32'd1);
      step();

      // Old value at 0x20, then reset during the wait of a new write.
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h20, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'h2020_2020);
      step();
      step();
      step();
      set_bus(1'b1, TR_NONSEQ, 1'b1, 32'h20, 32'h0);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'hFFFF_0000);
      chk("ws rst pre hready", 32'(hready2), 32'd0);
      #2;
      resetN = 1'b0;
      #1;
      chk("ws async rst hready", 32'(hready2), 32'd1);
      chk("ws async rst hresp", 32'(hresp2), 32'd0);
      chk("ws async rst hrdata", hrdata2, 32'h0);
      step();
      step();
      resetN = 1'b1;
      set_bus(1'b1, TR_NONSEQ, 1'b0, 32'h20, 32'hFFFF_0000);
      step();
      set_bus(1'b0, TR_IDLE, 1'b0, 32'h0, 32'hFFFF_0000);
      step();
      step();
      chk("ws r20 hready", 32'(hready2), 32'd1);
      chk("ws r20 old value", hrdata2, 32'h2020_2020);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/ahb_sram_slave.md
AHB_SRAM_SLAVE -- requirements
Module: ahb_sram_slave

Interface
REQ-001 Parameter DEPTH, default 256, number of 32-bit words in the memory (power of two, 16..4096).
REQ-002 Parameter WAIT_STATES, default 0, hready-low cycles inserted per OKAY data phase (range 0..3).
REQ-003 hclk  input  1  bus clock; the only clock; all state updates on its rising edge.
REQ-004 resetN  input  1  reset, asynchronous, active-low.
REQ-005 hsel  input  1  slave select, qualifies the address phase.
REQ-006 haddr  input  32  byte address; word index = haddr[log2(DEPTH)+1:2].
REQ-007 hwdata  input  32  write data, valid in the write data phase.
REQ-008 hwrite  input  1  1 = write, 0 = read; sampled with the address phase.
REQ-009 htrans  input  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ.
REQ-010 hready  output  1  data phase complete; also used internally as the bus hready.
REQ-011 hresp  output  2  00 OKAY, 01 ERROR.
REQ-012 hrdata  output  32  read data.

Function
REQ-013 Address phase SHALL be accepted at a rising hclk edge when hsel=1, htrans[1]=1 and hready=1; haddr, hwrite and the word index are registered at that edge.
REQ-014 IDLE/BUSY transfers and hsel=0 SHALL produce no memory access and a zero-wait OKAY response.
REQ-015 FSM states: IDLE, WAIT, ERR1, ERR2; IDLE drives hready=1, hresp=OKAY.
REQ-016 Accepted legal transfer with WAIT_STATES=0: data phase is the next cycle, hready=1, hresp=OKAY, FSM stays IDLE.
REQ-017 Accepted legal transfer with WAIT_STATES=N>0: IDLE->WAIT; hready=0 for exactly N cycles, then hready=1 with OKAY; WAIT->IDLE.
REQ-018 Write: hwdata SHALL be stored to mem[index] at the edge ending the data-phase cycle with hready=1.
REQ-019 Read: hrdata SHALL equal mem[index] during the data-phase cycle with hready=1; hrdata holds its previous value otherwise.
REQ-020 Read accepted in the data phase of a write to the same index SHALL return the newly written data (forwarding).
REQ-021 Unaligned access (haddr[1:0]!=00) SHALL give a two-cycle ERROR: ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01), then IDLE; no memory write, hrdata unchanged.
REQ-022 An address phase presented during ERR2 SHALL be accepted (hready=1 in ERR2).
REQ-023 Back-to-back NONSEQ/SEQ transfers SHALL sustain one transfer per cycle when WAIT_STATES=0.
REQ-024 Address inputs presented while hready=0 SHALL be ignored until hready returns high.

Reset
REQ-025 resetN low SHALL immediately force FSM=IDLE, hready=1, hresp=00, hrdata=32'h0 and discard any pending transfer.
REQ-026 Memory contents SHALL NOT be reset; a write pending when resetN asserts SHALL NOT be performed.
REQ-027 First address phase SHALL be accepted at the first rising hclk edge after resetN deasserts.

Configuration
REQ-028 Macro AHB_SRAM_SLAVE_RANGE_CHECK_EN defined: access with haddr >= 4*DEPTH SHALL give the REQ-021 ERROR response with no memory access.
REQ-029 Macro AHB_SRAM_SLAVE_RANGE_CHECK_EN undefined: upper address bits ignored, index wraps modulo DEPTH, response OKAY.

Verification
REQ-030 WAIT_STATES=0: write 32'hDEAD_BEEF to 0x10, then read 0x10 back-to-back -> hrdata=32'hDEAD_BEEF in the read data phase, hready never low, hresp=00.
REQ-031 WAIT_STATES=2: read 0x04 -> hready low exactly 2 cycles, then high with correct data and hresp=00.
REQ-032 Access to 0x0000_0002 -> ERR1 (hready=0, hresp=01), ERR2 (hready=1, hresp=01); memory at 0x0 unchanged on readback.
REQ-033 Range check, DEPTH=256, access 0x400: with macro defined -> two-cycle ERROR; without it -> OKAY, aliases word 0.
REQ-034 resetN pulsed low during a WAIT cycle of a write to 0x20 -> outputs at reset values immediately; readback of 0x20 shows the old value.
REQ-035 htrans=IDLE with hsel=1 and htrans=NONSEQ with hsel=0 -> OKAY, hready=1, no memory change.
